// File: rtl/sha_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sha : modes, round counts and control states shared with datapath  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package sha;

  typedef enum logic [2:0] {
    SHA1       = 3'd0,
    SHA224     = 3'd1,
    SHA256     = 3'd2,
    SHA384     = 3'd3,
    SHA512     = 3'd4,
    SHA512_224 = 3'd5,
    SHA512_256 = 3'd6
  } mode_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ROUND = 3'd2,
    ST_ADD   = 3'd3,
    ST_OUT   = 3'd4
  } state_t;

  localparam logic [6:0] C_ROUNDS_SHA256 = 7'd64;
  localparam logic [6:0] C_ROUNDS_OTHER  = 7'd80;
  localparam logic [6:0] C_SCHED_START   = 7'd16;

  function automatic logic [6:0] num_rounds(input mode_t m);
    if (m == SHA224 || m == SHA256) return C_ROUNDS_SHA256;
    return C_ROUNDS_OTHER;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sha_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sha_ctrl : block sequencing FSM for a SHA-1/SHA-2 round datapath   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module sha_ctrl
  import sha::*;
#(
  parameter int UNROLL = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  mode_t      mode,
  input  logic       blk_valid,
  output logic       blk_ready,
  input  logic       blk_first,
  input  logic       blk_last,
  input  logic       abort,
  output mode_t      mode_q,
  output logic       init_hash,
  output logic       msg_load,
  output logic       round_en,
  output logic [6:0] round_idx,
  output logic       sched_sel,
  output logic       add_hash,
  output logic       hash_valid,
  input  logic       hash_ready,
  output logic       busy
);

  localparam logic [6:0] C_STEP = 7'(UNROLL);

  state_t     r_state, w_state_nxt;
  logic [6:0] r_idx, w_idx_nxt;
  mode_t      r_mode, w_mode_nxt;
  logic       r_in_msg, w_in_msg_nxt;
  logic       r_last, w_last_nxt;
  logic       r_init, w_init_nxt;
  logic       w_restart;
  logic       w_last_round;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_idx    <= 7'd0;
      r_mode   <= SHA1;
      r_in_msg <= 1'b0;
      r_last   <= 1'b0;
      r_init   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_idx    <= w_idx_nxt;
      r_mode   <= w_mode_nxt;
      r_in_msg <= w_in_msg_nxt;
      r_last   <= w_last_nxt;
      r_init   <= w_init_nxt;
    end
  end

  // A new message starts on blk_first or whenever nothing is in progress
  assign w_restart    = blk_first || !r_in_msg;
  assign w_last_round = (r_idx == (num_rounds(r_mode) - C_STEP));

  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_mode_nxt   = r_mode;
    w_in_msg_nxt = r_in_msg;
    w_last_nxt   = r_last;
    w_init_nxt   = r_init;
    blk_ready    = 1'b0;
    init_hash    = 1'b0;
    msg_load     = 1'b0;
    round_en     = 1'b0;
    sched_sel    = 1'b0;
    add_hash     = 1'b0;
    hash_valid   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        blk_ready = 1'b1;
        if (blk_valid && !abort) begin
          w_state_nxt  = ST_LOAD;
          w_last_nxt   = blk_last;
          w_init_nxt   = w_restart;
          w_in_msg_nxt = 1'b1;
          if (w_restart) w_mode_nxt = mode;
        end
      end
      ST_LOAD: begin
        msg_load    = 1'b1;
        init_hash   = r_init;
        w_idx_nxt   = 7'd0;
        w_state_nxt = ST_ROUND;
      end
      ST_ROUND: begin
        round_en  = 1'b1;
        sched_sel = (r_idx >= C_SCHED_START);
        if (w_last_round) begin
          w_idx_nxt   = 7'd0;
          w_state_nxt = ST_ADD;
        end else begin
          w_idx_nxt = r_idx + C_STEP;
        end
      end
      ST_ADD: begin
        add_hash    = !abort;
        w_state_nxt = r_last ? ST_OUT : ST_IDLE;
      end
      ST_OUT: begin
        hash_valid = !abort;
        if (hash_ready) begin
          w_state_nxt  = ST_IDLE;
          w_in_msg_nxt = 1'b0;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    if (abort) begin
      w_state_nxt  = ST_IDLE;
      w_idx_nxt    = 7'd0;
      w_in_msg_nxt = 1'b0;
    end
  end

  assign round_idx = r_idx;
  assign mode_q    = r_mode;
  assign busy      = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sha_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_sha_ctrl : directed checks of sha_ctrl sequencing, UNROLL=1/2   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_sha_ctrl;
  import sha::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mode_t      mode = SHA1;
  logic       blk_valid = 0, blk_first = 0, blk_last = 0, abort = 0, hash_ready = 0;
  logic       blk_ready, init_hash, msg_load, round_en, sched_sel, add_hash, hash_valid, busy;
  logic [6:0] round_idx;
  mode_t      mode_q;

  mode_t      mode_2 = SHA1;
  logic       blk_valid_2 = 0, blk_first_2 = 0, blk_last_2 = 0, abort_2 = 0, hash_ready_2 = 0;
  logic       blk_ready_2, init_hash_2, msg_load_2, round_en_2, sched_sel_2, add_hash_2;
  logic       hash_valid_2, busy_2;
  logic [6:0] round_idx_2;
  mode_t      mode_q_2;

  sha_ctrl #(.UNROLL(1)) u_dut1 (
    .clk(clk), .rst(rst), .mode(mode), .blk_valid(blk_valid), .blk_ready(blk_ready),
    .blk_first(blk_first), .blk_last(blk_last), .abort(abort), .mode_q(mode_q),
    .init_hash(init_hash), .msg_load(msg_load), .round_en(round_en), .round_idx(round_idx),
    .sched_sel(sched_sel), .add_hash(add_hash), .hash_valid(hash_valid),
    .hash_ready(hash_ready), .busy(busy)
  );

  sha_ctrl #(.UNROLL(2)) u_dut2 (
    .clk(clk), .rst(rst), .mode(mode_2), .blk_valid(blk_valid_2), .blk_ready(blk_ready_2),
    .blk_first(blk_first_2), .blk_last(blk_last_2), .abort(abort_2), .mode_q(mode_q_2),
    .init_hash(init_hash_2), .msg_load(msg_load_2), .round_en(round_en_2),
    .round_idx(round_idx_2), .sched_sel(sched_sel_2), .add_hash(add_hash_2),
    .hash_valid(hash_valid_2), .hash_ready(hash_ready_2), .busy(busy_2)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offers one block at the current IDLE cycle, then presents mode_after so
  // that a mid-message mode change can be seen to be ignored. Returns when
  // hash_valid rises or the controller drops back to IDLE.
  task automatic run_block(input mode_t m, input logic f, input logic l, input mode_t mode_after,
                           output int n_round, output int n_add, output int n_init,
                           output int lat, output int n_valid, output bit seq_ok);
    int exp_idx;
    n_round = 0; n_add = 0; n_init = 0; lat = -1; n_valid = 0; seq_ok = 1; exp_idx = 0;
    mode = m; blk_valid = 1; blk_first = f; blk_last = l;
    step();
    blk_valid = 0; blk_first = 0; blk_last = 0; mode = mode_after;
    for (int cyc = 1; cyc < 300; cyc++) begin
      if (init_hash) n_init++;
      if (round_en) begin
        n_round++;
        if (round_idx != 7'(exp_idx) || sched_sel != (exp_idx >= 16)) seq_ok = 0;
        exp_idx++;
      end
      if (add_hash) n_add++;
      if (hash_valid) begin n_valid++; lat = cyc; break; end
      if (!busy) begin lat = cyc; break; end
      step();
    end
  endtask

  task automatic release_out();
    hash_ready = 1;
    step();
    hash_ready = 0;
  endtask

  int  nr, na, ni, lat, nv;
  bit  sok;
  bit  stable;
  bit  found;
  int  exp_idx2;

  initial begin
    #1;
    check("rst_blk_ready", blk_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_round_idx", round_idx, 0);
    check("rst_mode_q", mode_q, SHA1);
    check("rst_pulses", {init_hash, msg_load, round_en, sched_sel, add_hash, hash_valid}, 0);
    step();
    rst = 0;
    step();

    // sha256 single block
    run_block(SHA256, 1, 1, SHA1, nr, na, ni, lat, nv, sok);
    check("s256_round_en", nr, 64);
    check("s256_add", na, 1);
    check("s256_init", ni, 1);
    check("s256_latency", lat, 67);
    check("s256_valid", nv, 1);
    check("s256_idx_seq", sok, 1);
    check("s256_mode_q", mode_q, SHA256);
    stable = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (!hash_valid || blk_ready || !busy) stable = 0;
    end
    check("out_hold_stable", stable, 1);
    release_out();
    check("out_release_idle", {busy, blk_ready}, 2'b01);

    // sha512 two-block message, mode change on second block ignored
    run_block(SHA512, 1, 0, SHA256, nr, na, ni, lat, nv, sok);
    check("s512_b1_round_en", nr, 80);
    check("s512_b1_add", na, 1);
    check("s512_b1_init", ni, 1);
    check("s512_b1_to_idle", lat, 83);
    check("s512_b1_no_valid", nv, 0);
    run_block(SHA256, 0, 1, SHA256, nr, na, ni, lat, nv, sok);
    check("s512_b2_round_en", nr, 80);
    check("s512_b2_add", na, 1);
    check("s512_b2_no_init", ni, 0);
    check("s512_b2_latency", lat, 83);
    check("s512_b2_valid", nv, 1);
    check("s512_mode_held", mode_q, SHA512);
    release_out();

    // abort at round_idx 30
    mode = SHA256; blk_valid = 1; blk_first = 1; blk_last = 0;
    step();
    blk_valid = 0; blk_first = 0;
    found = 0;
    for (int i = 0; i < 200; i++) begin
      if (round_en && round_idx == 7'd30) begin found = 1; break; end
      step();
    end
    check("abort_reach_idx30", found, 1);
    abort = 1;
    #1;
    check("abort_no_add", add_hash, 0);
    step();
    abort = 0;
    check("abort_idle", {busy, blk_ready}, 2'b01);
    check("abort_idx_cleared", round_idx, 0);
    run_block(SHA224, 0, 1, SHA1, nr, na, ni, lat, nv, sok);
    check("post_abort_init", ni, 1);
    check("post_abort_mode", mode_q, SHA224);
    check("s224_round_en", nr, 64);
    check("s224_latency", lat, 67);
    abort = 1;
    #1;
    check("abort_suppress_valid", hash_valid, 0);
    step();
    abort = 0;
    check("abort_out_idle", busy, 0);

    // abort together with blk_valid in IDLE: no accept
    abort = 1; blk_valid = 1; blk_first = 1; mode = SHA512;
    step();
    abort = 0; blk_valid = 0; blk_first = 0;
    check("abort_wins_accept", busy, 0);
    check("abort_wins_mode", mode_q, SHA224);

    // blk_first mid-message restarts with a re-sampled mode
    run_block(SHA384, 1, 0, SHA384, nr, na, ni, lat, nv, sok);
    check("s384_b1_round_en", nr, 80);
    run_block(SHA256, 1, 1, SHA1, nr, na, ni, lat, nv, sok);
    check("restart_init", ni, 1);
    check("restart_mode", mode_q, SHA256);
    check("restart_round_en", nr, 64);
    release_out();

    // reset mid-ROUND
    mode = SHA1; blk_valid = 1; blk_first = 1; blk_last = 1;
    step();
    blk_valid = 0; blk_first = 0; blk_last = 0;
    for (int i = 0; i < 10; i++) step();
    check("pre_rst_in_round", round_en, 1);
    rst = 1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_blk_ready", blk_ready, 1);
    check("midrst_round_idx", round_idx, 0);
    check("midrst_pulses", {init_hash, msg_load, round_en, sched_sel, add_hash, hash_valid}, 0);
    step();
    rst = 0;
    step();

    // sha1 with UNROLL=2
    mode_2 = SHA1; blk_valid_2 = 1; blk_first_2 = 1; blk_last_2 = 1;
    step();
    blk_valid_2 = 0; blk_first_2 = 0; blk_last_2 = 0;
    nr = 0; lat = -1; sok = 1; exp_idx2 = 0;
    for (int cyc = 1; cyc < 200; cyc++) begin
      if (round_en_2) begin
        nr++;
        if (round_idx_2 != 7'(exp_idx2) || sched_sel_2 != (exp_idx2 >= 16)) sok = 0;
        exp_idx2 += 2;
      end
      if (hash_valid_2) begin lat = cyc; break; end
      step();
    end
    check("u2_round_en", nr, 40);
    check("u2_idx_seq", sok, 1);
    check("u2_latency", lat, 43);
    hash_ready_2 = 1;
    step();
    hash_ready_2 = 0;
    check("u2_idle", busy_2, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
